// File: rtl/tff_counter_ctrl.sv
// Command sequencer for an external bank of WIDTH T flip-flops: counts up/down N
// steps or loads a value by generating per-bit toggle enables from the fed-back q.
module tff_counter_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             abort,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] t_out,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_UP   = 2'b01,
      S_DOWN = 2'b10,
      S_LOAD = 2'b11
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] remaining, remaining_n;
   logic [WIDTH-1:0] target, target_n;
   logic             done_n, wrap_n;
   logic             accept;
   logic [WIDTH-1:0] up_t, dn_t;

   assign cmd_ready = (state == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE);

   // Bit i toggles when all lower bits are ones (up) or all zeros (down).
   always_comb begin
      logic [WIDTH-1:0] mask;
      up_t = '0;
      dn_t = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         mask    = WIDTH'((1 << i) - 1);
         up_t[i] = ((q_in & mask) == mask);
         dn_t[i] = ((q_in & mask) == '0);
      end
   end

   always_comb begin
      t_out = '0;
      if (!rst && !abort) begin
         case (state)
            S_UP:    t_out = up_t;
            S_DOWN:  t_out = dn_t;
            S_LOAD:  t_out = q_in ^ target;
            default: t_out = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         remaining <= '0;
         target    <= '0;
         done      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         target    <= target_n;
         done      <= done_n;
         wrap      <= wrap_n;
      end
   end

   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      target_n    = target;
      done_n      = 1'b0;
      wrap_n      = wrap;
      case (state)
         S_IDLE: begin
            if (accept) begin
               wrap_n = 1'b0;
               case (cmd_op)
                  OP_NOP: done_n = 1'b1;
                  OP_UP, OP_DOWN: begin
                     if (cmd_arg == '0) begin
                        done_n = 1'b1;
                     end else begin
                        remaining_n = cmd_arg;
                        state_n     = (cmd_op == OP_UP) ? S_UP : S_DOWN;
                     end
                  end
                  OP_LOAD: begin
                     target_n = cmd_arg;
                     state_n  = S_LOAD;
                  end
                  default: done_n = 1'b0;
               endcase
            end
         end
         S_UP, S_DOWN: begin
            if (abort) begin
               state_n     = S_IDLE;
               remaining_n = '0;
            end else begin
               if ((state == S_UP) ? (&q_in) : (~|q_in)) wrap_n = 1'b1;
               remaining_n = remaining - WIDTH'(1);
               if (remaining == WIDTH'(1)) begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         S_LOAD: begin
            state_n = S_IDLE;
            done_n  = !abort;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl: T flip-flop bank model, directed scenarios with literal
// expectations, and randomized commands checked each cycle against an arithmetic model.
module tb_tff_counter_ctrl;

   localparam int unsigned W    = 4;
   localparam int unsigned MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_arg = '0;
   logic         abort = 1'b0;
   logic [W-1:0] q;
   logic [W-1:0] t_out;
   logic         busy, done, wrap;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // reference model: 0 idle, 1 counting up, 2 counting down, 3 loading
   int           m_kind = 0;
   int           m_rem = 0;
   logic [W-1:0] m_tgt = '0;
   logic [W-1:0] mq = '0;
   bit           m_done = 1'b0;
   bit           m_wrap = 1'b0;

   always #5 clk = ~clk;

   tff_counter_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .q_in(q),
      .t_out(t_out), .busy(busy), .done(done), .wrap(wrap)
   );

   // the external flip-flop bank
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= q ^ t_out;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_t();
      if (rst || abort || m_kind == 0) return '0;
      case (m_kind)
         1:       return mq ^ W'(mq + 1'b1);
         2:       return mq ^ W'(mq - 1'b1);
         default: return mq ^ m_tgt;
      endcase
   endfunction

   always @(posedge clk) begin
      bit nd;
      nd = 1'b0;
      if (rst) begin
         m_kind = 0; m_rem = 0; mq = '0; m_wrap = 1'b0;
      end else if (m_kind == 0) begin
         if (cmd_valid) begin
            m_wrap = 1'b0;
            if (cmd_op == 2'd0) nd = 1'b1;
            else if (cmd_op == 2'd3) begin m_tgt = cmd_arg; m_kind = 3; end
            else if (cmd_arg == '0) nd = 1'b1;
            else begin m_rem = int'(cmd_arg); m_kind = int'(cmd_op); end
         end
      end else if (abort) begin
         m_kind = 0; m_rem = 0;
      end else if (m_kind == 3) begin
         mq = m_tgt; m_kind = 0; nd = 1'b1;
      end else begin
         if (m_kind == 1) begin
            if (int'(mq) == MAXV) m_wrap = 1'b1;
            mq = W'(mq + 1'b1);
         end else begin
            if (mq == '0) m_wrap = 1'b1;
            mq = W'(mq - 1'b1);
         end
         m_rem--;
         if (m_rem == 0) begin m_kind = 0; nd = 1'b1; end
      end
      m_done = nd;
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("q", int'(q), int'(mq));
         chk("t_out", int'(t_out), int'(exp_t()));
         chk("cmd_ready", int'(cmd_ready), int'(m_kind == 0 && !rst));
         chk("busy", int'(busy), int'(m_kind != 0));
         chk("done", int'(done), int'(m_done));
         chk("wrap", int'(wrap), int'(m_wrap));
      end
   end

   // Presents a command, waits for acceptance, returns at the negedge after the accept edge.
   task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] arg);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      for (int n = 0; n < 64; n++) begin
         #1;
         if (cmd_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("accept_timeout", int'(ok), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk); #1;
         if (!busy && !done) begin ok = 1'b1; break; end
      end
      chk("idle_timeout", int'(ok), 1);
   endtask

   initial begin
      logic [W-1:0] up5 [5];
      up5 = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001};

      @(negedge clk);
      chk_en = 1'b1;
      #1;
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_t", int'(t_out), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;

      // UP 5 from 0
      do_cmd(2'b01, 4'd5);
      for (int i = 0; i < 5; i++) begin
         #1; chk("up5_t", int'(t_out), int'(up5[i]));
         @(negedge clk);
      end
      #1;
      chk("up5_q", int'(q), 5);
      chk("up5_done", int'(done), 1);
      chk("up5_ready", int'(cmd_ready), 1);
      chk("up5_wrap", int'(wrap), 0);

      // LOAD 14 then UP 3 across the wrap
      do_cmd(2'b11, 4'd14);
      #1; chk("load14_t", int'(t_out), 4'b1011);
      @(negedge clk); #1;
      chk("load14_q", int'(q), 14);
      chk("load14_done", int'(done), 1);
      do_cmd(2'b01, 4'd3);
      repeat (3) @(negedge clk);
      #1;
      chk("up3_q", int'(q), 1);
      chk("up3_wrap", int'(wrap), 1);
      chk("up3_done", int'(done), 1);

      // DOWN 2 from 1 wraps; LOAD 9 clears wrap on accept
      do_cmd(2'b10, 4'd2);
      repeat (2) @(negedge clk);
      #1;
      chk("dn2_q", int'(q), 15);
      chk("dn2_wrap", int'(wrap), 1);
      do_cmd(2'b11, 4'd9);
      #1;
      chk("load9_wrap", int'(wrap), 0);
      chk("load9_t", int'(t_out), 4'b0110);
      @(negedge clk); #1;
      chk("load9_q", int'(q), 9);
      chk("load9_done", int'(done), 1);

      // zero-step UP, NOP, and a command held while busy
      do_cmd(2'b01, 4'd0);
      #1;
      chk("up0_done", int'(done), 1);
      chk("up0_busy", int'(busy), 0);
      do_cmd(2'b00, 4'd7);
      #1;
      chk("nop_done", int'(done), 1);
      chk("nop_q", int'(q), 9);
      do_cmd(2'b01, 4'd3);
      do_cmd(2'b01, 4'd1);
      wait_idle();
      chk("held_q", int'(q), 13);

      // abort on the third toggle cycle of UP 10 from 0
      do_cmd(2'b11, 4'd0);
      wait_idle();
      do_cmd(2'b01, 4'd10);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      #1; chk("abort_t", int'(t_out), 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("abort_q", int'(q), 2);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);

      // reset in the middle of DOWN
      do_cmd(2'b10, 4'd7);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_ready", int'(cmd_ready), 0);
      chk("mrst_t", int'(t_out), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_q", int'(q), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done", int'(done), 0);
      chk("mrst_wrap", int'(wrap), 0);

      // randomized traffic, checked by the per-cycle model comparison
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_arg   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, MAXV)) : W'($urandom_range(0, 4));
         abort     = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 79) == 0);
      end
      @(negedge clk);
      cmd_valid = 1'b0; abort = 1'b0; rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tff_counter_ctrl.md
Name: tff_counter_ctrl

Overview:
- Sequencer for an external bank of WIDTH synchronous T flip-flops. Each flip-flop toggles on a clk edge when its t input is 1 and holds when it is 0. Zero-delay flip-flops share this block's clk and rst.
- Accepts commands over a valid/ready handshake: count up N steps, count down N steps, or load a value.
- Generates the per-bit toggle enables from the bank's fed-back q, and reports completion and wrap-around.

Parameters:
- WIDTH, 4, number of flip-flops in the bank; also the width of cmd_arg.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset: synchronous, active-high. Also drives the bank's reset, so q = 0 after reset.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, block can accept a command.
- cmd_op, input, 2, opcode: 00 NOP, 01 UP, 10 DOWN, 11 LOAD.
- cmd_arg, input, WIDTH, step count N for UP/DOWN; target value for LOAD.
- abort, input, 1, synchronous cancel of the running command.
- q_in, input, WIDTH, current q of the flip-flop bank.
- t_out, output, WIDTH, toggle enables to the bank (combinational from state, abort and q_in).
- busy, output, 1, high while state is not IDLE.
- done, output, 1, one-cycle pulse after a command completes.
- wrap, output, 1, sticky: a wrap-around occurred during the current or last command.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, remaining=0, done=0, wrap=0.
  - cmd_ready=0 and t_out=0 while rst is high.
  - rst mid-command aborts it immediately with no done pulse.
- FSM states: IDLE, UP, DOWN, LOAD.
  - cmd_ready = (state==IDLE) && !rst.
  - Handshake fires on a clk edge when cmd_valid && cmd_ready.
  - cmd_valid with cmd_ready low is ignored; the requester holds it.
- On accept:
  - wrap is cleared.
  - NOP: stays IDLE; done pulses the next cycle.
  - UP/DOWN with N=0: stays IDLE; done pulses the next cycle; no toggles.
  - UP/DOWN with N>0: remaining=N; next state is UP or DOWN.
  - LOAD: latch target=cmd_arg; next state is LOAD.
- UP:
  - t_out[0]=1; t_out[i] = AND of q_in[i-1:0].
  - Each edge: remaining decrements.
  - If q_in is all ones, wrap is set.
  - When remaining==1 at the edge: go to IDLE and set done for the next cycle.
- DOWN:
  - t_out[0]=1; t_out[i] = NOR of q_in[i-1:0].
  - Wrap is set when q_in==0.
  - Termination is the same as UP.
- LOAD:
  - t_out = q_in XOR target, for exactly one cycle.
  - Then IDLE, with done the next cycle. Loading the current value yields t_out=0 but still pulses done.
- Latency:
  - Command accepted at edge k; toggles applied at edges k+1..k+N.
  - done high during the cycle after edge k+N, in which cmd_ready is also high.
  - Back-to-back accept is allowed on the edge that ends the done cycle.
- abort:
  - While abort=1, t_out=0.
  - If state is not IDLE at the edge: go to IDLE, remaining=0, no done, wrap retained.
  - In IDLE, abort has no effect and does not block accept.
- t_out is 0 in IDLE. busy = (state!=IDLE).
- remaining is WIDTH bits wide, so N up to 2^WIDTH-1.
- Count arithmetic is modulo 2^WIDTH.

Test Plan:
- Reset, then UP N=5 from q=0 → t_out pattern 0001, 0011, 0001, 0111, 0001 at edges 1-5; q=5; done one cycle after the 5th toggle; wrap=0.
- LOAD 4'b1110 then UP N=3 → q goes 14, 15, 0, 1; wrap=1 set at the 15→0 step; done after 3 toggles.
- DOWN N=2 from q=1 → q goes 0 then 15; wrap=1. A following LOAD 9 clears wrap on accept, t_out=0110 for one cycle, q=9, done pulses.
- UP N=0 and NOP → no toggles; done pulses the cycle after accept; cmd_valid held during busy is not accepted until cmd_ready=1.
- UP N=10 with abort asserted at the 3rd toggle cycle → t_out=0 that cycle; q=2; IDLE next cycle; no done. Then rst mid-DOWN → q=0, all outputs at reset values.
